id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection for the pipelined MIPS core. It captures decoded operands and control from the decode stage, resolves RAW hazards against the MEM and WB stages, and drives SrcA/SrcB/ALUCtr directly into the execute-stage ALU. It also flags load-use hazards so decode can stall, and injects the required bubble itself.

## Interface
- No parameters. Data width fixed at 32, register index at 5, ALU control at 4.
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  global freeze from downstream; EX contents held.
- flush  in  1  branch/jump squash; EX becomes a bubble.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs, id_rt, id_rd  in  5 each  source and destination register indices.
- id_rs_data, id_rt_data  in  32 each  register-file read data.
- id_imm  in  32  sign-extended immediate.
- id_alu_src  in  1  1 = src_b takes the immediate.
- id_alu_ctr  in  4  ALU operation code.
- id_reg_dst  in  1  1 = write register is rd, 0 = rt.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  downstream control.
- mem_reg_write  in  1;  mem_rd  in  5;  mem_result  in  32  MEM-stage forwarding source.
- wb_reg_write  in  1;  wb_rd  in  5;  wb_result  in  32  WB-stage forwarding source.
- ex_valid  out  1  EX holds a real instruction.
- src_a, src_b  out  32 each  forwarded ALU operands.
- alu_ctr  out  4  registered ALU operation.
- ex_store_data  out  32  forwarded rt value for stores.
- ex_write_reg  out  5  resolved destination index.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control, gated by ex_valid.
- load_use_hazard  out  1  combinational; decode must hold its instruction this cycle.

## Operation
- Register update priority on each rising clk: flush > stall > load_use_hazard > normal load.
- flush: ex_valid and all control bits cleared, alu_ctr = 0000. Data fields are don't-care.
- stall: all fields held, except stored rs/rt data, which are overwritten with their current forwarded values. A WB result that retires during the freeze is therefore not lost.
- load_use_hazard (without stall/flush): load a bubble, identical to flush.
- Normal load: capture all id_* fields, with ex_valid = id_valid and control bits ANDed with id_valid.
  - ex_write_reg = id_reg_dst ? id_rd : id_rt.
- Forwarding for each operand, on the stored rs (resp. rt) index r:
  - If mem_reg_write, mem_rd == r and r != 0, use mem_result.
  - Else if wb_reg_write, wb_rd == r and r != 0, use wb_result.
  - Otherwise use the stored data.
  - MEM has priority over WB. Register 0 is never forwarded.
- src_a = forwarded rs. ex_store_data = forwarded rt. src_b = alu_src ? stored imm : forwarded rt.
- load_use_hazard = ex_valid & ex_mem_read & (ex_write_reg != 0) & id_valid & (ex_write_reg == id_rs | ex_write_reg == id_rt).

## Timing
- Reset (rst_n low, asynchronous): every register cleared; all outputs 0, including ex_valid, src_a, src_b, alu_ctr and load_use_hazard.
- Reset asserted mid-stall or mid-hazard clears the state immediately; the first edge after release performs a normal load.
- Latency: one cycle from id_* to the registered outputs.
- Forwarding and src_a/src_b are combinational from registered state plus the mem_*/wb_* inputs, in the same cycle.
- load_use_hazard is combinational and asserts in the cycle a load sits in EX with a matching decode instruction. It deasserts the next cycle because EX then holds the bubble. Exactly one bubble is inserted per load-use pair.
- stall and hazard in the same cycle: stall wins, EX holds, and the hazard re-evaluates after the stall.
- flush and stall in the same cycle: flush wins.

## Structure
- Shared package mips_pkg holds:
  - ALU control constants: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
  - Forward-select encoding: FWD_REG, FWD_MEM, FWD_WB.
  - Register-index width 5 and data width 32.
- One sub-module, fwd_unit: takes an index, the stored data and the mem_*/wb_* inputs, and returns the forwarded data. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset: hold rst_n low with id_valid = 1 -> all outputs 0. Release, then load ADD with rs_data 5, rt_data 7 -> next cycle src_a = 5, src_b = 7, alu_ctr = 0010, ex_valid = 1.
- Forwarding priority: EX rs = 3, mem_rd = 3 with mem_result 0x10, wb_rd = 3 with wb_result 0x20 -> src_a = 0x10. Drop mem_reg_write -> src_a = 0x20. With rs = 0 -> stored data, never forwarded.
- Load-use: EX holds lw with write reg 8; ID has rs = 8 -> load_use_hazard = 1. Next cycle ex_valid = 0, hazard = 0. The following cycle the dependent instruction loads.
- Stall capture: stall for 2 cycles while wb_rd = rt with wb_result 0x55 for one cycle only -> after release src_b = 0x55 (alu_src = 0).
- Flush vs stall: flush = stall = 1 with a valid EX -> next cycle ex_valid = 0 and ex_reg_write = 0.
- Immediate and store path: sw with alu_src = 1, imm 0xFFFFFFFC, forwarded rt 0x99 from MEM -> src_b = 0xFFFFFFFC, ex_store_data = 0x99, ex_write_reg = rt.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core.
//   - Data / register-index / ALU-control widths
//   - ALU control encodings
//   - Forwarding source select encoding
//   - fwd_hit(): RAW match test used by the forwarding logic
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ALU_W  = 4;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // A producer only matches when it actually writes, targets the same
    // register, and that register is not $zero.
    function automatic logic fwd_hit(input logic             wr_en,
                                     input logic [REG_W-1:0] wr_idx,
                                     input logic [REG_W-1:0] rd_idx);
        return wr_en && (wr_idx == rd_idx) && (rd_idx != '0);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux for one EX source operand.
//   i_idx           : source register index held in EX
//   i_data          : register-file data captured with the instruction
//   i_mem_*         : MEM-stage write-back candidate (highest priority)
//   i_wb_*          : WB-stage write-back candidate
//   o_data          : forwarded operand value
module fwd_unit
    import mips_pkg::*;
(
    input  logic [REG_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_mem_reg_write,
    input  logic [REG_W-1:0]  i_mem_rd,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic              i_wb_reg_write,
    input  logic [REG_W-1:0]  i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_result,
    output logic [DATA_W-1:0] o_data
);

    fwd_sel_e w_sel;

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        w_sel = FWD_REG;
        if (fwd_hit(i_mem_reg_write, i_mem_rd, i_idx))
            w_sel = FWD_MEM;
        else if (fwd_hit(i_wb_reg_write, i_wb_rd, i_idx))
            w_sel = FWD_WB;
    end

    always_comb begin
        o_data = i_data;
        case (w_sel)
            FWD_MEM: o_data = i_mem_result;
            FWD_WB:  o_data = i_wb_result;
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding and load-use bubble insertion.
// Inputs : clk, rst_n, stall, flush, decode-stage instruction (id_*),
//          MEM / WB forwarding sources (mem_*, wb_*).
// Outputs: ex_valid, forwarded ALU operands src_a/src_b, alu_ctr,
//          ex_store_data, ex_write_reg, registered control (ex_*),
//          combinational load_use_hazard for the decode stall.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic [ALU_W-1:0]  id_alu_ctr,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] src_a,
    output logic [DATA_W-1:0] src_b,
    output logic [ALU_W-1:0]  alu_ctr,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              load_use_hazard
);

    logic              r_valid;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic              r_alu_src;
    logic [ALU_W-1:0]  r_alu_ctr;
    logic [REG_W-1:0]  r_write_reg;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;

    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic              w_hazard;

    fwd_unit u_fwd_rs (
        .i_idx           (r_rs),
        .i_data          (r_rs_data),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd        (mem_rd),
        .i_mem_result    (mem_result),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_result     (wb_result),
        .o_data          (w_fwd_rs)
    );

    fwd_unit u_fwd_rt (
        .i_idx           (r_rt),
        .i_data          (r_rt_data),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_rd        (mem_rd),
        .i_mem_result    (mem_result),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_result     (wb_result),
        .o_data          (w_fwd_rt)
    );

    assign w_hazard = r_valid && r_mem_read && (r_write_reg != '0) && id_valid &&
                      ((r_write_reg == id_rs) || (r_write_reg == id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_alu_src    <= 1'b0;
            r_alu_ctr    <= '0;
            r_write_reg  <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (flush || (!stall && w_hazard)) begin
            // Bubble: only validity and control matter, data is left as-is.
            r_valid      <= 1'b0;
            r_alu_ctr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (stall) begin
            // Refresh operands with forwarded values so a producer that
            // retires from WB while EX is frozen is not lost.
            r_rs_data <= w_fwd_rs;
            r_rt_data <= w_fwd_rt;
        end else begin
            r_valid      <= id_valid;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
            r_alu_src    <= id_alu_src;
            r_alu_ctr    <= id_alu_ctr;
            r_write_reg  <= id_reg_dst ? id_rd : id_rt;
            r_reg_write  <= id_reg_write  & id_valid;
            r_mem_read   <= id_mem_read   & id_valid;
            r_mem_write  <= id_mem_write  & id_valid;
            r_mem_to_reg <= id_mem_to_reg & id_valid;
        end
    end

    assign ex_valid        = r_valid;
    assign src_a           = w_fwd_rs;
    assign src_b           = r_alu_src ? r_imm : w_fwd_rt;
    assign alu_ctr         = r_alu_ctr;
    assign ex_store_data   = w_fwd_rt;
    assign ex_write_reg    = r_write_reg;
    assign ex_reg_write    = r_reg_write  & r_valid;
    assign ex_mem_read     = r_mem_read   & r_valid;
    assign ex_mem_write    = r_mem_write  & r_valid;
    assign ex_mem_to_reg   = r_mem_to_reg & r_valid;
    assign load_use_hazard = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use
// bubble, stall capture, flush-vs-stall, immediate/store path, reset
// during a hazard.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_ctr;
    logic        id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] src_a, src_b, ex_store_data;
    logic [3:0]  alu_ctr;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_hazard;

    int n_pass  = 0;
    int n_total = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctr(id_alu_ctr), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_valid(ex_valid), .src_a(src_a), .src_b(src_b), .alu_ctr(alu_ctr),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic asrc, input logic [3:0] actr,
                          input logic rdst, input logic rw, input logic mr, input logic mw,
                          input logic m2r);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_rd = rd;
        id_rs_data = rsd;  id_rt_data = rtd;  id_imm = imm;
        id_alu_src = asrc;  id_alu_ctr = actr;  id_reg_dst = rdst;
        id_reg_write = rw;  id_mem_read = mr;  id_mem_write = mw;  id_mem_to_reg = m2r;
    endtask

    task automatic no_fwd();
        mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
        wb_reg_write  = 1'b0; wb_rd  = 5'd0; wb_result  = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        no_fwd();
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset with a live decode instruction and a clock edge inside reset
        #12;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_src_a", src_a, 32'h0);
        chk("rst_src_b", src_b, 32'h0);
        chk("rst_alu_ctr", {28'b0, alu_ctr}, 32'h0);
        chk("rst_hazard", {31'b0, load_use_hazard}, 32'h0);
        chk("rst_reg_write", {31'b0, ex_reg_write}, 32'h0);

        // First load: ADD r3 = r1 + r2
        rst_n = 1'b1;
        step();
        chk("add_src_a", src_a, 32'd5);
        chk("add_src_b", src_b, 32'd7);
        chk("add_alu_ctr", {28'b0, alu_ctr}, {28'b0, ALU_ADD});
        chk("add_ex_valid", {31'b0, ex_valid}, 32'h1);
        chk("add_write_reg", {27'b0, ex_write_reg}, 32'd3);
        chk("add_reg_write", {31'b0, ex_reg_write}, 32'h1);

        // Forwarding priority on rs = 3
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h0, 1'b0, ALU_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'h10;
        wb_reg_write  = 1'b1; wb_rd  = 5'd3; wb_result  = 32'h20;
        #1;
        chk("fwd_mem_over_wb", src_a, 32'h10);
        chk("fwd_rt_untouched", src_b, 32'h2);
        mem_reg_write = 1'b0;
        #1;
        chk("fwd_wb", src_a, 32'h20);

        // rs = 0 is never forwarded
        set_id(1'b1, 5'd0, 5'd4, 5'd5, 32'h77, 32'h2, 32'h0, 1'b0, ALU_OR, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'h10;
        wb_reg_write  = 1'b1; wb_rd  = 5'd0; wb_result  = 32'h20;
        #1;
        chk("fwd_r0_stored", src_a, 32'h77);
        no_fwd();

        // Load-use: lw r8, then add r10 = r8 + r9
        set_id(1'b1, 5'd2, 5'd8, 5'd0, 32'h0, 32'h0, 32'h4, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("lw_write_reg", {27'b0, ex_write_reg}, 32'd8);
        chk("lw_mem_read", {31'b0, ex_mem_read}, 32'h1);
        set_id(1'b1, 5'd8, 5'd9, 5'd10, 32'h100, 32'h200, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_hazard_on", {31'b0, load_use_hazard}, 32'h1);
        step();
        chk("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
        chk("lu_bubble_rw", {31'b0, ex_reg_write}, 32'h0);
        chk("lu_hazard_off", {31'b0, load_use_hazard}, 32'h0);
        step();
        chk("lu_dep_valid", {31'b0, ex_valid}, 32'h1);
        chk("lu_dep_write_reg", {27'b0, ex_write_reg}, 32'd10);
        chk("lu_dep_src_b", src_b, 32'h200);

        // Stall two cycles; WB retires r9 = 0x55 during the first only
        stall = 1'b1;
        set_id(1'b1, 5'd1, 5'd2, 5'd11, 32'hAAA, 32'hBBB, 32'h0, 1'b0, ALU_AND, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wb_reg_write = 1'b1; wb_rd = 5'd9; wb_result = 32'h55;
        step();
        no_fwd();
        #1;
        chk("stall1_src_b", src_b, 32'h55);
        step();
        stall = 1'b0;
        #1;
        chk("stall_rel_src_b", src_b, 32'h55);
        chk("stall_held_src_a", src_a, 32'h100);
        chk("stall_held_write_reg", {27'b0, ex_write_reg}, 32'd10);
        chk("stall_held_alu", {28'b0, alu_ctr}, {28'b0, ALU_ADD});
        step();
        chk("post_stall_load", {27'b0, ex_write_reg}, 32'd11);
        chk("post_stall_valid", {31'b0, ex_valid}, 32'h1);

        // Flush beats stall
        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        chk("flush_valid", {31'b0, ex_valid}, 32'h0);
        chk("flush_reg_write", {31'b0, ex_reg_write}, 32'h0);
        chk("flush_alu", {28'b0, alu_ctr}, 32'h0);

        // sw with immediate offset, rt forwarded from MEM
        set_id(1'b1, 5'd5, 5'd6, 5'd0, 32'h1000, 32'h1, 32'hFFFFFFFC, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        mem_reg_write = 1'b1; mem_rd = 5'd6; mem_result = 32'h99;
        #1;
        chk("sw_src_b_imm", src_b, 32'hFFFFFFFC);
        chk("sw_store_data", ex_store_data, 32'h99);
        chk("sw_write_reg", {27'b0, ex_write_reg}, 32'd6);
        chk("sw_mem_write", {31'b0, ex_mem_write}, 32'h1);
        chk("sw_src_a", src_a, 32'h1000);
        no_fwd();

        // Reset asserted while a load-use hazard is pending
        set_id(1'b1, 5'd2, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_id(1'b1, 5'd8, 5'd9, 5'd12, 32'h3, 32'h4, 32'h0, 1'b0, ALU_SLT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_mid_hazard_pre", {31'b0, load_use_hazard}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_mid_hazard", {31'b0, load_use_hazard}, 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        chk("rst_rel_valid", {31'b0, ex_valid}, 32'h1);
        chk("rst_rel_write_reg", {27'b0, ex_write_reg}, 32'd12);
        chk("rst_rel_alu", {28'b0, alu_ctr}, {28'b0, ALU_SLT});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
